// File: rtl/mem_pkg.sv
// mem_pkg: shared opcodes, funct3 encodings, FSM states and load formatting
package mem_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t HOLD = 2'd2;
  function automatic logic [63:0] ld_fmt(input logic [63:0] w, input logic [1:0] sz, input logic uns);
    ld_fmt = sz == SZ_B ? {{56{~uns & w[7]}}, w[7:0]} :
             sz == SZ_H ? {{48{~uns & w[15]}}, w[15:0]} :
             sz == SZ_W ? {{32{~uns & w[31]}}, w[31:0]} : w;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, strobes, load extension and misalignment check
module lsu_align import mem_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   sdata,
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata,
  output logic              misaligned
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  logic [OW-1:0] off;
  logic [OW+2:0] sh;
  logic [7:0] mask;
  logic [XLEN-1:0] lane;
  // shift store data up to its lane and the addressed load lane down to bit 0
  always_comb begin
    off = addr[OW-1:0];
    sh = {off, 3'b000};
    mask = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    wstrb = mask[NB-1:0] << off;
    wdata = sdata << sh;
    lane = rdata >> sh;
    ldata = XLEN'(ld_fmt(64'(lane), size, uns));
    misaligned = (size == SZ_H & addr[0]) | (size == SZ_W & |addr[1:0]) |
                 (size == SZ_D & ((XLEN == 32) | |addr[2:0]));
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage with branch resolve, data-memory LSU and MEM/WB latch; MEM_STAGE_PERF_EN adds counters
module mem_stage_lsu import mem_pkg::*; #(
  parameter int          XLEN      = 64,
  parameter logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] DMEM_SIZE = 64'h0000_0000_0001_0000,
  parameter int          REG_W     = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_STALL,
  input  logic              MEM_V,
  input  logic [6:0]        MEM_OPCODE,
  input  logic [2:0]        MEM_FUNCT3,
  input  logic [XLEN-1:0]   MEM_NPC,
  input  logic [XLEN-1:0]   MEM_CSRFD,
  input  logic [XLEN-1:0]   MEM_ALU_RESULT,
  input  logic [XLEN-1:0]   MEM_SR1,
  input  logic [XLEN-1:0]   MEM_SR2,
  input  logic [XLEN-1:0]   MEM_RFD,
  input  logic [REG_W-1:0]  MEM_DRID,
  input  logic              MEM_ECALL,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN-1:0]   DMEM_WDATA,
  output logic [XLEN/8-1:0] DMEM_WSTRB,
  input  logic              DMEM_READY,
  input  logic              DMEM_RVALID,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  output logic              MEM_PC_MUX,
  output logic              MEM_STALL,
  output logic              MEM_LAM,
  output logic              MEM_LAF,
  output logic              MEM_SAM,
  output logic              MEM_SAF,
  output logic [XLEN-1:0]   WB_NPC,
  output logic [XLEN-1:0]   WB_CSRFD,
  output logic [XLEN-1:0]   WB_ALU_RESULT,
  output logic [XLEN-1:0]   WB_MEM_RESULT,
  output logic [XLEN-1:0]   WB_RFD,
  output logic              WB_PC_MUX,
  output logic              WB_V,
  output logic              WB_ECALL,
`ifdef MEM_STAGE_PERF_EN
  output logic [63:0]       PERF_LOADS,
  output logic [63:0]       PERF_STORES,
  output logic [63:0]       PERF_STALLS,
`endif
  output logic [REG_W-1:0]  WB_DRID
);
  localparam int OW = $clog2(XLEN / 8);
  state_t state, state_nx;
  logic is_load, is_store, memop, taken, mis, fault, flag, retire;
  logic [63:0] a64, rel;
  logic [XLEN-1:0] ldata, hold_data, res;
  lsu_align #(.XLEN(XLEN)) u_align (
    .addr(MEM_ALU_RESULT),
    .sdata(MEM_SR2),
    .rdata(DMEM_RDATA),
    .size(MEM_FUNCT3[1:0]),
    .uns(MEM_FUNCT3[2]),
    .wstrb(DMEM_WSTRB),
    .wdata(DMEM_WDATA),
    .ldata(ldata),
    .misaligned(mis)
  );
  // decode, redirect, fault classification and handshake control
  always_comb begin
    is_load = MEM_OPCODE == OP_LOAD;
    is_store = MEM_OPCODE == OP_STORE;
    memop = is_load | is_store;
    taken = MEM_OPCODE == OP_JAL | MEM_OPCODE == OP_JALR | (MEM_OPCODE == OP_BRANCH & (
      MEM_FUNCT3 == F3_BEQ  ? MEM_SR1 == MEM_SR2 :
      MEM_FUNCT3 == F3_BNE  ? MEM_SR1 != MEM_SR2 :
      MEM_FUNCT3 == F3_BLT  ? $signed(MEM_SR1) < $signed(MEM_SR2) :
      MEM_FUNCT3 == F3_BGE  ? $signed(MEM_SR1) >= $signed(MEM_SR2) :
      MEM_FUNCT3 == F3_BLTU ? MEM_SR1 < MEM_SR2 :
      MEM_FUNCT3 == F3_BGEU ? MEM_SR1 >= MEM_SR2 : 1'b0));
    a64 = 64'(MEM_ALU_RESULT);
    rel = a64 - DMEM_BASE;
    fault = memop & ~mis & (a64 < DMEM_BASE | rel >= DMEM_SIZE);
    flag = (memop & mis) | fault;
    MEM_PC_MUX = MEM_V & taken;
    MEM_LAM = MEM_V & is_load & mis;
    MEM_LAF = MEM_V & is_load & fault;
    MEM_SAM = MEM_V & is_store & mis;
    MEM_SAF = MEM_V & is_store & fault;
    DMEM_REQ = ~RESET & MEM_V & memop & ~flag & state == IDLE;
    DMEM_WE = is_store;
    DMEM_ADDR = {MEM_ALU_RESULT[XLEN-1:OW], {OW{1'b0}}};
    retire = MEM_V & ~WB_STALL & (~memop | flag | state == HOLD | (state == WAIT & DMEM_RVALID));
    MEM_STALL = MEM_V & ~retire;
    res = state == HOLD ? hold_data : (is_load & ~flag) ? ldata : '0;
    state_nx = state == IDLE ? (DMEM_REQ & DMEM_READY ? WAIT : IDLE) :
               state == WAIT ? (DMEM_RVALID ? (WB_STALL ? HOLD : IDLE) : WAIT) :
               WB_STALL ? HOLD : IDLE;
  end
  // access FSM and buffer for a response that arrives while writeback is stalled
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      hold_data <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT & DMEM_RVALID & WB_STALL) hold_data <= res;
    end
  end
  // MEM/WB latch: load on retire, bubble when writeback is free, otherwise hold
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WB_NPC <= '0;
      WB_CSRFD <= '0;
      WB_ALU_RESULT <= '0;
      WB_MEM_RESULT <= '0;
      WB_RFD <= '0;
      WB_PC_MUX <= 1'b0;
      WB_V <= 1'b0;
      WB_ECALL <= 1'b0;
      WB_DRID <= '0;
    end else if (retire) begin
      WB_NPC <= MEM_NPC;
      WB_CSRFD <= MEM_CSRFD;
      WB_ALU_RESULT <= MEM_ALU_RESULT;
      WB_MEM_RESULT <= res;
      WB_RFD <= MEM_RFD;
      WB_PC_MUX <= MEM_PC_MUX;
      WB_V <= 1'b1;
      WB_ECALL <= MEM_ECALL;
      WB_DRID <= MEM_DRID;
    end else if (~WB_STALL) begin
      WB_V <= 1'b0;
    end
  end
`ifdef MEM_STAGE_PERF_EN
  // retired-access and stall-cycle counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PERF_LOADS <= '0;
      PERF_STORES <= '0;
      PERF_STALLS <= '0;
    end else begin
      PERF_LOADS <= PERF_LOADS + 64'(retire & is_load & ~flag);
      PERF_STORES <= PERF_STORES + 64'(retire & is_store & ~flag);
      PERF_STALLS <= PERF_STALLS + 64'(MEM_STALL);
    end
  end
`endif
endmodule
